// File: rtl/fwd_rd_pipe.sv
// fwd_rd_pipe: destination-register tracking pipeline (IS -> EX -> WB slots).
// Carries {valid, we, load, rd} for each in-flight instruction and presents the
// effective rd of every slot to the forwarding unit (0 = no forward).
// Optional feature macro: FWD_LOAD_USE_STALL_EN enables load-use stall detection
// and the saturating hazard-stall cycle counter. Without it the stall request and
// the counter output are constant 0.

module fwd_rd_pipe #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dec_valid_in,
    input  logic [ADDR_W-1:0] dec_rd_addr_in,
    input  logic              dec_rd_we_in,
    input  logic              dec_is_load_in,
    input  logic [ADDR_W-1:0] dec_rs1_addr_in,
    input  logic [ADDR_W-1:0] dec_rs2_addr_in,
    input  logic              pipe_stall_in,
    input  logic              pipe_flush_in,
    output logic [ADDR_W-1:0] is_rd_addr_out,
    output logic [ADDR_W-1:0] ex_rd_addr_out,
    output logic [ADDR_W-1:0] wb_rd_addr_out,
    output logic              hazard_stall_out,
    output logic [CNT_W-1:0]  hazard_cnt_out
);

    // Slot state; a bubble is all-zero.
    logic              is_valid, is_we, is_load;
    logic [ADDR_W-1:0] is_rd;
    logic              ex_valid, ex_we, ex_load;
    logic [ADDR_W-1:0] ex_rd;
    logic              wb_valid, wb_we, wb_load;
    logic [ADDR_W-1:0] wb_rd;

    logic              hazard_stall;

    // Effective rd per slot: only a valid write to a non-zero register forwards.
    assign is_rd_addr_out = (is_valid && is_we && (is_rd != '0)) ? is_rd : '0;
    assign ex_rd_addr_out = (ex_valid && ex_we && (ex_rd != '0)) ? ex_rd : '0;
    assign wb_rd_addr_out = (wb_valid && wb_we && (wb_rd != '0)) ? wb_rd : '0;

    assign hazard_stall_out = hazard_stall;

`ifdef FWD_LOAD_USE_STALL_EN
    logic             rs_match;
    logic [CNT_W-1:0] hazard_cnt;
    logic             unused_sink;

    assign rs_match = (dec_rs1_addr_in == is_rd) || (dec_rs2_addr_in == is_rd);

    // A flush kills the load in IS, so it never needs a stall.
    assign hazard_stall = dec_valid_in & is_valid & is_load & is_we & (is_rd != '0) &
                          rs_match & ~pipe_flush_in;

    // Saturating count of stall cycles that actually took effect (not frozen).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hazard_cnt <= '0;
        end else if (hazard_stall && !pipe_stall_in && (hazard_cnt != {CNT_W{1'b1}})) begin
            hazard_cnt <= hazard_cnt + CNT_W'(1);
        end
    end

    assign hazard_cnt_out = hazard_cnt;

    // The load flag is carried into WB but nothing downstream consumes it.
    assign unused_sink = wb_load;
`else
    logic unused_sink;

    assign hazard_stall   = 1'b0;
    assign hazard_cnt_out = '0;

    // Source operands and the WB load flag have no consumer in this build.
    assign unused_sink = ^{dec_rs1_addr_in, dec_rs2_addr_in, wb_load};
`endif

    // Slot advance: flush > external stall > load-use bubble > normal capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            is_valid <= 1'b0;
            is_we    <= 1'b0;
            is_load  <= 1'b0;
            is_rd    <= '0;
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_load  <= 1'b0;
            ex_rd    <= '0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_load  <= 1'b0;
            wb_rd    <= '0;
        end else if (pipe_flush_in) begin
            is_valid <= 1'b0;
            is_we    <= 1'b0;
            is_load  <= 1'b0;
            is_rd    <= '0;
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_load  <= 1'b0;
            ex_rd    <= '0;
            // The older instruction in EX survives the redirect unless frozen.
            if (!pipe_stall_in) begin
                wb_valid <= ex_valid;
                wb_we    <= ex_we;
                wb_load  <= ex_load;
                wb_rd    <= ex_rd;
            end
        end else if (!pipe_stall_in) begin
            if (hazard_stall) begin
                is_valid <= 1'b0;
                is_we    <= 1'b0;
                is_load  <= 1'b0;
                is_rd    <= '0;
            end else begin
                is_valid <= dec_valid_in;
                is_we    <= dec_rd_we_in;
                is_load  <= dec_is_load_in;
                is_rd    <= dec_rd_addr_in;
            end
            ex_valid <= is_valid;
            ex_we    <= is_we;
            ex_load  <= is_load;
            ex_rd    <= is_rd;
            wb_valid <= ex_valid;
            wb_we    <= ex_we;
            wb_load  <= ex_load;
            wb_rd    <= ex_rd;
        end
    end

endmodule

// File: tb/tb_fwd_rd_pipe.sv
// Self-checking bench for fwd_rd_pipe: directed scenarios plus randomized traffic,
// compared against a slot-array reference model. Follows FWD_LOAD_USE_STALL_EN.

module tb_fwd_rd_pipe;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef FWD_LOAD_USE_STALL_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    logic              clk_in;
    logic              rst_in;
    logic              dec_valid_in;
    logic [ADDR_W-1:0] dec_rd_addr_in;
    logic              dec_rd_we_in;
    logic              dec_is_load_in;
    logic [ADDR_W-1:0] dec_rs1_addr_in;
    logic [ADDR_W-1:0] dec_rs2_addr_in;
    logic              pipe_stall_in;
    logic              pipe_flush_in;
    logic [ADDR_W-1:0] is_rd_addr_out;
    logic [ADDR_W-1:0] ex_rd_addr_out;
    logic [ADDR_W-1:0] wb_rd_addr_out;
    logic              hazard_stall_out;
    logic [CNT_W-1:0]  hazard_cnt_out;

    fwd_rd_pipe #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .dec_valid_in     (dec_valid_in),
        .dec_rd_addr_in   (dec_rd_addr_in),
        .dec_rd_we_in     (dec_rd_we_in),
        .dec_is_load_in   (dec_is_load_in),
        .dec_rs1_addr_in  (dec_rs1_addr_in),
        .dec_rs2_addr_in  (dec_rs2_addr_in),
        .pipe_stall_in    (pipe_stall_in),
        .pipe_flush_in    (pipe_flush_in),
        .is_rd_addr_out   (is_rd_addr_out),
        .ex_rd_addr_out   (ex_rd_addr_out),
        .wb_rd_addr_out   (wb_rd_addr_out),
        .hazard_stall_out (hazard_stall_out),
        .hazard_cnt_out   (hazard_cnt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [ADDR_W-1:0] rd;
    } slot_t;

    // Reference: m[0]=IS, m[1]=EX, m[2]=WB.
    slot_t m[3];
    int    m_cnt;
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] eff(input slot_t s);
        return (s.v && s.we && (s.rd != 0)) ? 32'(s.rd) : 32'd0;
    endfunction

    function automatic logic model_hz(input logic v, input logic [ADDR_W-1:0] rs1,
                                      input logic [ADDR_W-1:0] rs2, input logic fl);
        return HZ_EN && v && m[0].v && m[0].ld && m[0].we && (m[0].rd != 0) &&
               ((rs1 == m[0].rd) || (rs2 == m[0].rd)) && !fl;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '0;
        m_cnt = 0;
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_is_rd"}, is_rd_addr_out, eff(m[0]));
        check({pfx, "_ex_rd"}, ex_rd_addr_out, eff(m[1]));
        check({pfx, "_wb_rd"}, wb_rd_addr_out, eff(m[2]));
        check({pfx, "_cnt"}, hazard_cnt_out, m_cnt);
    endtask

    // Called at a negedge: drive inputs, compare, take one rising edge, update model.
    task automatic step(input logic v, input logic we, input logic ld,
                        input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                        input logic [ADDR_W-1:0] rs2, input logic st, input logic fl);
        logic  hz;
        slot_t wb_n;
        dec_valid_in    = v;
        dec_rd_we_in    = we;
        dec_is_load_in  = ld;
        dec_rd_addr_in  = rd;
        dec_rs1_addr_in = rs1;
        dec_rs2_addr_in = rs2;
        pipe_stall_in   = st;
        pipe_flush_in   = fl;
        #1;
        hz = model_hz(v, rs1, rs2, fl);
        check_all("step");
        check("step_hazard", hazard_stall_out, hz);
        @(posedge clk_in);
        if (fl) begin
            wb_n = st ? m[2] : m[1];
            m[0] = '0;
            m[1] = '0;
            m[2] = wb_n;
        end else if (!st) begin
            m[2] = m[1];
            m[1] = m[0];
            m[0] = hz ? slot_t'('0) : slot_t'({v, we, ld, rd});
        end
        if (hz && !st && m_cnt < CNT_MAX) m_cnt++;
        @(negedge clk_in);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic accept(input logic [ADDR_W-1:0] rd, input logic ld);
        step(1'b1, 1'b1, ld, rd, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic              v, we, ld, st, fl;
        logic [ADDR_W-1:0] rd, rs1, rs2;

        rst_in          = 1'b1;
        dec_valid_in    = 1'b0;
        dec_rd_we_in    = 1'b0;
        dec_is_load_in  = 1'b0;
        dec_rd_addr_in  = '0;
        dec_rs1_addr_in = '0;
        dec_rs2_addr_in = '0;
        pipe_stall_in   = 1'b0;
        pipe_flush_in   = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_is_rd", is_rd_addr_out, 0);
        check("rst_ex_rd", ex_rd_addr_out, 0);
        check("rst_wb_rd", wb_rd_addr_out, 0);
        check("rst_hazard", hazard_stall_out, 0);
        check("rst_cnt", hazard_cnt_out, 0);
        rst_in = 1'b0;
        idle();

        // rd=5 walks IS -> EX -> WB -> gone.
        accept(5, 1'b0);
        check("lat_is5", is_rd_addr_out, 5);
        idle();
        check("lat_ex5", ex_rd_addr_out, 5);
        idle();
        check("lat_wb5", wb_rd_addr_out, 5);
        idle();
        check("lat_gone", wb_rd_addr_out, 0);

        // rd=0 with we, rd=7 without we never forward.
        accept(0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 7, '0, '0, 1'b0, 1'b0);
        check("nofwd_is", is_rd_addr_out, 0);
        idle();
        check("nofwd_ex", ex_rd_addr_out, 0);
        idle();
        check("nofwd_wb", wb_rd_addr_out, 0);

        // Load-use on rs2.
        accept(3, 1'b1);
        dec_valid_in    = 1'b1;
        dec_rs2_addr_in = 3;
        #1;
        check("lu_stall", hazard_stall_out, HZ_EN ? 1 : 0);
        step(1'b1, 1'b1, 1'b0, 9, 1, 3, 1'b0, 1'b0);
        check("lu_is_after", is_rd_addr_out, HZ_EN ? 0 : 9);
        check("lu_ex_after", ex_rd_addr_out, 3);
        check("lu_cnt_after", hazard_cnt_out, HZ_EN ? 1 : 0);
        dec_valid_in = 1'b1;
        #1;
        check("lu_one_cycle", hazard_stall_out, 0);

        // Flush with IS=4, EX=6, WB=2.
        accept(2, 1'b0);
        accept(6, 1'b0);
        accept(4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8, '0, '0, 1'b0, 1'b1);
        check("fl_is", is_rd_addr_out, 0);
        check("fl_ex", ex_rd_addr_out, 0);
        check("fl_wb", wb_rd_addr_out, 6);
        accept(2, 1'b0);
        accept(6, 1'b0);
        accept(4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8, '0, '0, 1'b1, 1'b1);
        check("flst_ex", ex_rd_addr_out, 0);
        check("flst_wb", wb_rd_addr_out, 2);

        // External stall freezes slots 1/2/3 with load-use pending.
        accept(3, 1'b0);
        accept(2, 1'b0);
        accept(1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 9, 1, 0, 1'b1, 1'b0);
        check("frz_is", is_rd_addr_out, 1);
        check("frz_ex", ex_rd_addr_out, 2);
        check("frz_wb", wb_rd_addr_out, 3);
        check("frz_cnt", hazard_cnt_out, HZ_EN ? 1 : 0);
        idle();

        // Asynchronous reset between edges with a full pipe.
        accept(11, 1'b0);
        accept(12, 1'b0);
        accept(13, 1'b1);
        #2 rst_in = 1'b1;
        #1;
        check("arst_is", is_rd_addr_out, 0);
        check("arst_ex", ex_rd_addr_out, 0);
        check("arst_wb", wb_rd_addr_out, 0);
        check("arst_cnt", hazard_cnt_out, 0);
        model_reset();
        dec_valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        idle();

        // Drive the counter into saturation, then stall once more.
        for (int i = 0; i < 20; i++) begin
            accept(3, 1'b1);
            step(1'b1, 1'b1, 1'b0, 4, 3, 0, 1'b0, 1'b0);
        end
        check("cnt_sat", hazard_cnt_out, HZ_EN ? CNT_MAX : 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(3) != 0);
            we  = ($urandom_range(3) != 0);
            ld  = ($urandom_range(1) != 0);
            rd  = ADDR_W'($urandom_range(7));
            rs1 = ($urandom_range(1) != 0) ? m[0].rd : ADDR_W'($urandom_range(7));
            rs2 = ($urandom_range(2) == 0) ? m[0].rd : ADDR_W'($urandom_range(7));
            st  = ($urandom_range(7) == 0);
            fl  = ($urandom_range(9) == 0);
            step(v, we, ld, rd, rs1, rs2, st, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
